// File: rtl/bp_update_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_arbiter_pkg
// Description : Shared defaults and pending-update entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_update_arbiter_pkg;

    localparam int c_DEPTH_DEF  = 4;
    localparam int c_ADDR_W_DEF = 32;

    // Queue entries are stored packed as {addr, taken}, matching this layout.
    typedef struct packed {
        logic [c_ADDR_W_DEF-1:0] addr;
        logic                    taken;
    } bp_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_update_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_arbiter_if
// Description : Request, control and predictor-update bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface bp_update_arbiter_if
    import bp_update_arbiter_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
);

    logic                     rdy;
    logic                     flush;
    logic                     req0_valid;
    logic [ADDR_W-1:0]        req0_addr;
    logic                     req0_taken;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [ADDR_W-1:0]        req1_addr;
    logic                     req1_taken;
    logic                     req1_ready;
    logic                     upd_en;
    logic                     upd_res;
    logic [ADDR_W-1:0]        upd_addr;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output rdy, flush,
        output req0_valid, req0_addr, req0_taken,
        output req1_valid, req1_addr, req1_taken,
        input  req0_ready, req1_ready,
        input  upd_en, upd_res, upd_addr, count
    );

    modport slave (
        input  rdy, flush,
        input  req0_valid, req0_addr, req0_taken,
        input  req1_valid, req1_addr, req1_taken,
        output req0_ready, req1_ready,
        output upd_en, upd_res, upd_addr, count
    );

endinterface
`default_nettype wire

// File: rtl/bp_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bp_upd_fifo
// Description : Pending-update FIFO, two write ports (wr0 lands first), one read.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_upd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 33
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      clr_i,
    input  wire logic                      wr0_en_i,
    input  wire logic [DATA_W-1:0]         wr0_data_i,
    input  wire logic                      wr1_en_i,
    input  wire logic [DATA_W-1:0]         wr1_data_i,
    input  wire logic                      rd_en_i,
    output logic      [DATA_W-1:0]         rd_data_o,
    output logic      [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [PTR_W-1:0]  w_wr1_ptr;

    // wr1 takes the slot after wr0 when both write, otherwise the tail slot.
    assign w_wr1_ptr = wr_ptr_q + PTR_W'(wr0_en_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en_i) + PTR_W'(wr1_en_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
        count_d  = count_q + CNT_W'(wr0_en_i) + CNT_W'(wr1_en_i) - CNT_W'(rd_en_i);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en_i) begin
            mem_q[wr_ptr_q] <= wr0_data_i;
        end
        if (wr1_en_i) begin
            mem_q[w_wr1_ptr] <= wr1_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/bp_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_arbiter
// Description : Merges two branch-resolution streams into one predictor update port.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_update_arbiter
    import bp_update_arbiter_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bp_update_arbiter_if.slave bus
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + 1;

    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_free;
    logic               w_active;
    logic               w_both;
    logic               w_contend;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_push0;
    logic               w_push1;
    logic               w_upd_en;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;

    // Capacity comes from the registered count only; a same-edge pop frees nothing.
    assign w_free   = CNT_W'(DEPTH) - w_count;
    assign w_active = bus.rdy && !bus.flush && !rst;
    assign w_both   = bus.req0_valid && bus.req1_valid;

    always_comb begin
        w_ready0  = 1'b0;
        w_ready1  = 1'b0;
        w_contend = 1'b0;
        if (w_active) begin
            if (w_free >= CNT_W'(2)) begin
                w_ready0 = 1'b1;
                w_ready1 = 1'b1;
            end else if (w_free == CNT_W'(1)) begin
                w_contend = w_both;
                w_ready0  = !w_both || !rr_q;
                w_ready1  = !w_both ||  rr_q;
            end
        end
    end

    assign w_push0  = bus.req0_valid && w_ready0;
    assign w_push1  = bus.req1_valid && w_ready1;
    assign w_upd_en = (w_count != '0) && !bus.flush && !rst;
    assign w_pop    = bus.rdy && w_upd_en;

    always_comb begin
        rr_d = rr_q;
        if (bus.flush) begin
            rr_d = 1'b0;
        end else if (w_contend) begin
            rr_d = !rr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    bp_upd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.flush),
        .wr0_en_i   (w_push0),
        .wr0_data_i ({bus.req0_addr, bus.req0_taken}),
        .wr1_en_i   (w_push1),
        .wr1_data_i ({bus.req1_addr, bus.req1_taken}),
        .rd_en_i    (w_pop),
        .rd_data_o  (w_head),
        .count_o    (w_count)
    );

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.upd_en     = w_upd_en;
    assign bus.upd_addr   = w_head[ENTRY_W-1:1];
    assign bus.upd_res    = w_head[0];
    assign bus.count      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_update_arbiter
// Description : Directed scenarios plus randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_update_arbiter;
    import bp_update_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_arbiter_if #(.DEPTH(DEPTH), .ADDR_W(32)) bus  ();
    bp_update_arbiter_if #(.DEPTH(2),     .ADDR_W(32)) bus2 ();

    bp_update_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    bp_update_arbiter #(.DEPTH(2),     .ADDR_W(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int        vectors     = 0;
    int        miscompares = 0;
    bp_entry_t mq[$];
    bit        m_rr = 1'b0;

    task automatic drive(input bit v0, input logic [31:0] a0, input bit t0,
                         input bit v1, input logic [31:0] a1, input bit t1,
                         input bit r, input bit f);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_taken = t0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_taken = t1;
        bus.rdy = r; bus.flush = f;
    endtask

    task automatic drive2(input bit v0, input logic [31:0] a0, input bit t0,
                          input bit v1, input logic [31:0] a1, input bit t1, input bit r);
        bus2.req0_valid = v0; bus2.req0_addr = a0; bus2.req0_taken = t0;
        bus2.req1_valid = v1; bus2.req1_addr = a1; bus2.req1_taken = t1;
        bus2.rdy = r; bus2.flush = 1'b0;
    endtask

    // Readiness from the capacity rules: free slots, then round-robin on a single slot.
    function automatic void exp_ready(output bit e0, output bit e1);
        int free;
        bit both;
        e0 = 1'b0; e1 = 1'b0;
        free = DEPTH - mq.size();
        both = bus.req0_valid && bus.req1_valid;
        if (rst || !bus.rdy || bus.flush) return;
        if (free >= 2) begin
            e0 = 1'b1; e1 = 1'b1;
        end else if (free == 1) begin
            if (both) begin e0 = !m_rr; e1 = m_rr; end
            else      begin e0 = 1'b1;  e1 = 1'b1; end
        end
    endfunction

    // Advance one edge, applying the same edge to the queue model.
    task automatic tick();
        bit e0, e1, v0, v1, r, f, cont;
        bp_entry_t n0, n1;
        exp_ready(e0, e1);
        v0 = bus.req0_valid; v1 = bus.req1_valid; r = bus.rdy; f = bus.flush;
        n0 = '{addr: bus.req0_addr, taken: bus.req0_taken};
        n1 = '{addr: bus.req1_addr, taken: bus.req1_taken};
        cont = v0 && v1 && r && !f && ((DEPTH - mq.size()) == 1);
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_rr = 1'b0;
        end else if (r) begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (v0 && e0) mq.push_back(n0);
            if (v1 && e1) mq.push_back(n1);
            if (cont) m_rr = !m_rr;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 32'h10, 1, 1, 32'h20, 0, 1, 0);
        drive2(1, 32'h10, 1, 1, 32'h20, 0, 1);
        #3;
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        vectors++; if (bus.upd_en !== 1'b0) begin miscompares++; $display("FAIL reset_upd_en: got %b want 0", bus.upd_en); end
        vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive2(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic test_single_push();
        drive(1, 32'h0000_1004, 1, 0, 0, 0, 1, 0);
        #3;
        vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        vectors++; if (bus.upd_en !== 1'b1) begin miscompares++; $display("FAIL single_upd_en: got %b want 1", bus.upd_en); end
        vectors++; if (bus.upd_addr !== 32'h0000_1004) begin miscompares++; $display("FAIL single_addr: got %h want 00001004", bus.upd_addr); end
        vectors++; if (bus.upd_res !== 1'b1) begin miscompares++; $display("FAIL single_res: got %b want 1", bus.upd_res); end
        tick();
        #3;
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL single_drain: got %0d want 0", bus.count); end
    endtask

    task automatic test_dual_push();
        drive(1, 32'h100, 1, 1, 32'h200, 0, 1, 0);
        #3;
        vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin miscompares++; $display("FAIL dual_ready: got %b want 11", {bus.req0_ready, bus.req1_ready}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        vectors++; if ({bus.upd_addr, bus.upd_res} !== {32'h100, 1'b1}) begin miscompares++; $display("FAIL dual_first: got %h/%b want 100/1", bus.upd_addr, bus.upd_res); end
        vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL dual_count: got %0d want 2", bus.count); end
        tick();
        #3;
        vectors++; if ({bus.upd_addr, bus.upd_res} !== {32'h200, 1'b0}) begin miscompares++; $display("FAIL dual_second: got %h/%b want 200/0", bus.upd_addr, bus.upd_res); end
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] seq [3];
        seq[0] = 32'h30c; seq[1] = 32'h310; seq[2] = 32'h31c;
        drive(1, 32'h300, 1, 1, 32'h304, 0, 1, 0); tick();
        drive(1, 32'h308, 1, 1, 32'h30c, 1, 1, 0); tick();
        drive(1, 32'h310, 0, 1, 32'h314, 1, 1, 0);
        #3;
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL cont_count: got %0d want 3", bus.count); end
        vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin miscompares++; $display("FAIL cont_grant0: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        tick();
        drive(1, 32'h318, 0, 1, 32'h31c, 1, 1, 0);
        #3;
        vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin miscompares++; $display("FAIL cont_grant1: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        tick();
        #3;
        vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin miscompares++; $display("FAIL cont_rr_back: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.upd_addr !== seq[i] || bus.upd_en !== 1'b1) begin miscompares++; $display("FAIL cont_order[%0d]: got %h en=%b want %h", i, bus.upd_addr, bus.upd_en, seq[i]); end
            tick();
        end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL cont_drain: got %0d want 0", bus.count); end
    endtask

    task automatic test_full_hold();
        drive2(1, 32'hA00, 1, 1, 32'hA04, 0, 1);
        tick();
        drive2(1, 32'hB00, 1, 1, 32'hB04, 1, 1);
        #3;
        vectors++; if ({bus2.req0_ready, bus2.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL full_ready: got %b want 00", {bus2.req0_ready, bus2.req1_ready}); end
        bus2.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (bus2.count !== 2'd2 || bus2.upd_addr !== 32'hA00) begin miscompares++; $display("FAIL full_hold[%0d]: got cnt=%0d head=%h want 2/a00", i, bus2.count, bus2.upd_addr); end
        end
        drive2(0, 0, 0, 0, 0, 0, 1);
        tick();
        #3;
        vectors++; if (bus2.count !== 2'd1 || bus2.upd_addr !== 32'hA04) begin miscompares++; $display("FAIL full_resume: got cnt=%0d head=%h want 1/a04", bus2.count, bus2.upd_addr); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 32'h500, 1, 1, 32'h504, 0, 1, 0); tick();
        drive(1, 32'h508, 0, 1, 32'h50c, 1, 1, 0); tick();
        drive(1, 32'h510, 1, 0, 0, 0, 1, 1);
        #3;
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count: got %0d want 3", bus.count); end
        vectors++; if ({bus.req0_ready, bus.upd_en} !== 2'b00) begin miscompares++; $display("FAIL flush_gate: got ready=%b upd_en=%b want 0/0", bus.req0_ready, bus.upd_en); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        vectors++; if (bus.count !== 3'd0 || bus.upd_en !== 1'b0) begin miscompares++; $display("FAIL flush_after: got cnt=%0d en=%b want 0/0", bus.count, bus.upd_en); end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h600, 1, 1, 32'h604, 1, 1, 0); tick();
        drive(1, 32'h700, 0, 0, 0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.count !== 3'd0 || bus.upd_en !== 1'b0) begin miscompares++; $display("FAIL arst_now: got cnt=%0d en=%b want 0/0", bus.count, bus.upd_en); end
        vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready: got %b want 0", bus.req0_ready); end
        #2 rst = 1'b0;
        mq.delete();
        m_rr = 1'b0;
        #1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        vectors++; if (bus.count !== 3'd1 || bus.upd_addr !== 32'h700 || bus.upd_res !== 1'b0) begin miscompares++; $display("FAIL arst_first_push: got cnt=%0d head=%h/%b want 1/700/0", bus.count, bus.upd_addr, bus.upd_res); end
        tick();
    endtask

    task automatic test_random();
        bit e0, e1, een;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), 32'h4000 + ($urandom_range(0, 3) << 2), $urandom_range(0, 1),
                  $urandom_range(0, 1), 32'h4000 + ($urandom_range(0, 3) << 2), $urandom_range(0, 1),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
            #3;
            exp_ready(e0, e1);
            een = (mq.size() != 0) && !bus.flush;
            vectors++; if ({bus.req0_ready, bus.req1_ready} !== {e0, e1}) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, {bus.req0_ready, bus.req1_ready}, {e0, e1}); end
            vectors++; if (bus.count !== 3'(mq.size())) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count, mq.size()); end
            vectors++; if (bus.upd_en !== een) begin miscompares++; $display("FAIL rnd_upd_en[%0d]: got %b want %b", i, bus.upd_en, een); end
            if (een) begin
                vectors++; if (bus.upd_addr !== mq[0].addr || bus.upd_res !== mq[0].taken) begin miscompares++; $display("FAIL rnd_head[%0d]: got %h/%b want %h/%b", i, bus.upd_addr, bus.upd_res, mq[0].addr, mq[0].taken); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_dual_push();
        test_contention();
        test_full_hold();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_update_arbiter.md
BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of pending-update queue entries (power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the branch PC width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rdy  input  1  global pipeline-ready; low freezes all state.
REQ-007 flush  input  1  discard all queued, unissued updates.
REQ-008 req0_valid  input  1  branch unit 0 presents a resolved branch.
REQ-009 req0_addr  input  ADDR_W  PC of resolved branch 0.
REQ-010 req0_taken  input  1  actual outcome of branch 0 (1 = taken).
REQ-011 req0_ready  output  1  request 0 accepted at this edge when valid.
REQ-012 req1_valid / req1_addr / req1_taken / req1_ready  input/input/input/output  1/ADDR_W/1/1  same as REQ-008..011 for branch unit 1.
REQ-013 upd_en  output  1  drives the predictor's update enable.
REQ-014 upd_res  output  1  outcome of the head entry.
REQ-015 upd_addr  output  ADDR_W  PC of the head entry.
REQ-016 count  output  clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-017 The block SHALL hold resolved-branch updates in a FIFO and issue at most one per cycle to the predictor's single update port.
REQ-018 free SHALL equal DEPTH - count, using the registered count; a pop in the same cycle SHALL NOT add capacity.
REQ-019 reqN_ready SHALL be 0 whenever rdy=0 or flush=1.
REQ-020 With free >= 2, both readys SHALL be 1; if both requests are valid, both SHALL be pushed in the same edge, req0 first.
REQ-021 With free = 1 and exactly one request valid, that request SHALL be granted.
REQ-022 With free = 1 and both requests valid, only the requester selected by round-robin bit rr (0 = req0) SHALL see ready=1.
REQ-023 rr SHALL toggle only on an edge where such a contention is resolved.
REQ-024 With free = 0, both readys SHALL be 0.
REQ-025 upd_en SHALL equal (count != 0) && !flush, combinationally.
REQ-026 upd_res and upd_addr SHALL reflect the head entry combinationally and are don't-care when upd_en=0.
REQ-027 The head SHALL pop on an edge with rdy=1 and upd_en=1; the predictor consumes it on that same edge.
REQ-028 Minimum latency SHALL be one cycle: data accepted at edge N appears on upd_* in the cycle after edge N, with no same-cycle bypass.
REQ-029 Push and pop on the same edge SHALL update count by (pushes - pops).
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Entries SHALL NOT be merged or reordered, including consecutive updates to the same PC.
REQ-032 With rdy=0, pointers, count and rr SHALL hold; upd_en may stay high, and the predictor ignores it.
REQ-033 On an edge with flush=1, regardless of rdy: count, both pointers and rr SHALL be 0; nothing SHALL be pushed or popped.
REQ-034 flush SHALL take priority over simultaneous push and pop.

Reset
REQ-035 While rst=1 (asynchronous): count=0, pointers=0, rr=0, entry storage need not be cleared.
REQ-036 While rst=1, upd_en=0 and req0_ready = req1_ready = 0.
REQ-037 The first push SHALL be possible on the first edge after rst deasserts.
REQ-038 Reset asserted mid-operation SHALL discard all pending entries.

Structure
REQ-039 A shared package SHALL hold DEPTH and ADDR_W defaults and the entry record {addr[ADDR_W], taken}.
REQ-040 The storage and pointers SHALL be one sub-module, bp_upd_fifo, with a 2-write/1-read port and count output.
REQ-041 Arbitration and flush logic SHALL reside in bp_update_arbiter.

Verification
REQ-042 Single push: req0 {0x0000_1004, taken=1} at edge 1 -> upd_en=1, upd_addr=0x0000_1004, upd_res=1 in cycle 2; count returns to 0 after edge 2.
REQ-043 Dual push, empty queue: req0 0x100/1 and req1 0x200/0 at same edge -> both ready=1; upd_* shows 0x100 then 0x200 on consecutive cycles.
REQ-044 Contention, count=3 with rdy high and head popping: both valid -> req0 granted, rr becomes 1; repeat at count=3 -> req1 granted, rr becomes 0.
REQ-045 Full queue: count=4 and both valid -> both ready=0; count stays 4 while rdy=0 for 5 cycles, and the head stays unchanged.
REQ-046 Flush with count=3 plus req0 valid -> ready=0 and upd_en=0 that cycle; count=0 next cycle and no update is issued.
REQ-047 Asynchronous rst pulse mid-cycle with count=2 -> count=0 and upd_en=0 immediately, without waiting for a clock edge.
